// File: rtl/spsram_pkg.sv
// Shared definitions for the single-port SRAM arbiter: FSM encoding,
// requester count and a small one-hot helper.
package spsram_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  // Requester index to one-hot vector.
  function automatic logic [NUM_REQ-1:0] onehot_idx(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spsram_rr_grant.sv
// Two-way round-robin grant. The grant is combinational from valid and the
// priority flop; priority moves to the other requester after each accept.
module spsram_rr_grant
  import spsram_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic prio;

  always_comb begin
    grant = '0;
    case (valid)
      2'b11:   grant = onehot_idx(prio);
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = '0;
    endcase
  end

  // Served requester loses priority on the next contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio <= 1'b0;
    end else if (accept && (|grant)) begin
      prio <= ~grant[1];
    end
  end

endmodule

// File: rtl/spsram_arbiter.sv
// Round-robin front end for one single-port sync SRAM: zero-fills the array
// after reset, then issues one granted read or write per cycle.
module spsram_arbiter
  import spsram_pkg::*;
#(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [NUM_REQ-1:0]         i_we,
  input  logic [NUM_REQ*BW_ADDR-1:0] i_addr,
  input  logic [NUM_REQ*BW_DATA-1:0] i_wdata,
  output logic [NUM_REQ-1:0]         o_ready,
  output logic [NUM_REQ-1:0]         o_rvalid,
  output logic [BW_DATA-1:0]         o_rdata,
  output logic                       o_init_done,
  output logic                       mem_cen,
  output logic                       mem_wen,
  output logic                       mem_oen,
  output logic [BW_ADDR-1:0]         mem_addr,
  output logic [BW_DATA-1:0]         mem_wdata,
  input  logic [BW_DATA-1:0]         mem_rdata
);

  state_t               state;
  state_t               state_nxt;
  logic [BW_ADDR-1:0]   cnt;
  logic                 init_done;
  logic [NUM_REQ-1:0]   rvalid;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   read_acc;
  logic                 serve;
  logic                 accept;
  logic                 gidx;
  logic                 we_g;
  logic [BW_ADDR-1:0]   addr_g;
  logic [BW_DATA-1:0]   wdata_g;

  assign serve  = (state == ST_SERVE);
  assign accept = serve & (|grant);
  assign gidx   = grant[1];

  spsram_rr_grant u_grant (
    .clk    (clk),
    .rstn   (rstn),
    .valid  (i_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Payload of the granted requester.
  always_comb begin
    we_g    = i_we[0];
    addr_g  = i_addr[0 +: BW_ADDR];
    wdata_g = i_wdata[0 +: BW_DATA];
    if (gidx) begin
      we_g    = i_we[1];
      addr_g  = i_addr[BW_ADDR +: BW_ADDR];
      wdata_g = i_wdata[BW_DATA +: BW_DATA];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant gating and SRAM port drive.
  always_comb begin
    state_nxt = state;
    o_ready   = '0;
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_INIT;
      end
      ST_INIT: begin
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = cnt;
        if (cnt == '1) begin
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        o_ready = grant;
        if (|grant) begin
          mem_cen   = 1'b1;
          mem_wen   = we_g;
          mem_addr  = addr_g;
          mem_wdata = wdata_g;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  assign mem_oen = mem_cen & ~mem_wen;

  // Zero-fill address counter, cleared outside INIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + BW_ADDR'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_done <= 1'b0;
    end else if ((state == ST_INIT) && (state_nxt == ST_SERVE)) begin
      init_done <= 1'b1;
    end
  end

  assign o_init_done = init_done;

  // Read return tag: one cycle behind the accepted read, matching SRAM latency.
  assign read_acc = (accept && !we_g) ? grant : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= '0;
    end else begin
      rvalid <= read_acc;
    end
  end

  assign o_rvalid = rvalid;
  assign o_rdata  = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_spsram_arbiter.sv
// Bench for spsram_arbiter with a sync SRAM model, a per-cycle reference
// model of the arbiter rules, and directed scenarios with literal checks.
module tb_spsram_arbiter;

  localparam int unsigned BW_DATA = 32;
  localparam int unsigned BW_ADDR = 5;
  localparam int unsigned DEPTH   = 32;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [1:0]             i_valid;
  logic [1:0]             i_we;
  logic [2*BW_ADDR-1:0]   i_addr;
  logic [2*BW_DATA-1:0]   i_wdata;
  logic [1:0]             o_ready;
  logic [1:0]             o_rvalid;
  logic [BW_DATA-1:0]     o_rdata;
  logic                   o_init_done;
  logic                   mem_cen;
  logic                   mem_wen;
  logic                   mem_oen;
  logic [BW_ADDR-1:0]     mem_addr;
  logic [BW_DATA-1:0]     mem_wdata;
  logic [BW_DATA-1:0]     mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spsram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_valid     (i_valid),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_ready     (o_ready),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_init_done (o_init_done),
    .mem_cen     (mem_cen),
    .mem_wen     (mem_wen),
    .mem_oen     (mem_oen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Sync SRAM model; scrambled while in reset so only the zero-fill can clear it.
  logic [BW_DATA-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: cycles since reset release, pending read return,
  // requester favoured on contention, and the expected memory contents.
  int                 mcyc = 0;
  logic               pend_v = 1'b0;
  logic               pend_tag = 1'b0;
  logic [BW_DATA-1:0] pend_data = '0;
  logic               favour = 1'b0;
  logic [BW_DATA-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin : compare
    logic [1:0]         e_ready;
    logic               e_cen;
    logic               e_wen;
    logic [BW_ADDR-1:0] e_addr;
    logic [BW_DATA-1:0] e_wdata;
    logic [1:0]         e_rvalid;
    logic [BW_DATA-1:0] e_rdata;
    logic               e_done;
    int                 g;
    e_ready = '0; e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
    e_done = 1'b0; g = -1;
    e_rvalid = pend_v ? (pend_tag ? 2'b10 : 2'b01) : 2'b00;
    e_rdata  = pend_v ? pend_data : '0;
    if (!rstn) begin
      e_rvalid = '0;
      e_rdata  = '0;
    end else if (mcyc >= 1 && mcyc <= DEPTH) begin
      e_cen = 1'b1; e_wen = 1'b1; e_addr = BW_ADDR'(mcyc - 1);
    end else if (mcyc > DEPTH) begin
      e_done = 1'b1;
      if (i_valid == 2'b11) g = favour ? 1 : 0;
      else if (i_valid[0])  g = 0;
      else if (i_valid[1])  g = 1;
      if (g >= 0) begin
        e_ready = 2'(2'b01 << g);
        e_cen   = 1'b1;
        e_wen   = i_we[g];
        e_addr  = i_addr[g*BW_ADDR +: BW_ADDR];
        e_wdata = i_wdata[g*BW_DATA +: BW_DATA];
      end
    end
    chk("o_ready", o_ready, e_ready);
    chk("o_rvalid", o_rvalid, e_rvalid);
    chk("o_rdata", o_rdata, e_rdata);
    chk("o_init_done", o_init_done, e_done);
    chk("mem_cen", mem_cen, e_cen);
    chk("mem_wen", mem_wen, e_wen);
    chk("mem_oen", mem_oen, e_cen & ~e_wen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    if (!rstn) begin
      mcyc = 0; pend_v = 1'b0; favour = 1'b0;
    end else begin
      pend_v = 1'b0;
      if (mcyc >= 1 && mcyc <= DEPTH) ref_mem[mcyc-1] = '0;
      if (g >= 0) begin
        if (i_we[g]) begin
          ref_mem[e_addr] = e_wdata;
        end else begin
          pend_v = 1'b1; pend_tag = g[0]; pend_data = ref_mem[e_addr];
        end
        favour = (g == 0);
      end
      if (mcyc <= DEPTH) mcyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [BW_ADDR-1:0] a,
                      input logic [BW_DATA-1:0] d);
    i_valid[0] = v; i_we[0] = we; i_addr[0 +: BW_ADDR] = a; i_wdata[0 +: BW_DATA] = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [BW_ADDR-1:0] a,
                      input logic [BW_DATA-1:0] d);
    i_valid[1] = v; i_we[1] = we; i_addr[BW_ADDR +: BW_ADDR] = a;
    i_wdata[BW_DATA +: BW_DATA] = d;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!o_init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : stim
    int n;
    rstn = 1'b1; i_valid = '0; i_we = '0; i_addr = '0; i_wdata = '0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: boot + 32 zero-fill cycles, done in cycle 34
    wait_init(n);
    chk("init_cycles", n, 34);

    // 2: write then read back, untouched address reads zero
    tick(); set0(1, 1, 3, 32'hDEAD_BEEF);
    @(negedge clk); chk("t2_wr_ready", o_ready, 2'b01);
    tick(); set0(1, 0, 3, 0);
    @(negedge clk); chk("t2_rd_ready", o_ready, 2'b01);
    tick(); set0(1, 0, 7, 0);
    @(negedge clk); chk("t2_rvalid", o_rvalid, 2'b01); chk("t2_rdata", o_rdata, 32'hDEAD_BEEF);
    tick(); set0(0, 0, 0, 0);
    @(negedge clk); chk("t2_rvalid7", o_rvalid, 2'b01); chk("t2_rdata7", o_rdata, 0);

    // 3: req1 write hands priority back to req0, then contended reads alternate
    tick(); set1(1, 1, 5, 32'h1111_5555);
    @(negedge clk); chk("t3_wr_ready", o_ready, 2'b10);
    tick(); set1(1, 0, 5, 0); set0(1, 0, 3, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_grant", o_ready, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("t3_rvalid", o_rvalid, (i % 2) ? 2'b01 : 2'b10);
        chk("t3_rdata", o_rdata, (i % 2) ? 32'hDEAD_BEEF : 32'h1111_5555);
      end
      tick();
      if (i == 5) begin
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
      end
    end
    @(negedge clk); chk("t3_rvalid_last", o_rvalid, 2'b10); chk("t3_rdata_last", o_rdata, 32'h1111_5555);

    // 4: write top address, read it the very next cycle, then address 0
    tick(); set1(1, 1, 31, 32'h5);
    @(negedge clk); chk("t4_wr_ready", o_ready, 2'b10);
    tick(); set1(0, 0, 0, 0); set0(1, 0, 31, 0);
    @(negedge clk); chk("t4_rd_ready", o_ready, 2'b01);
    tick(); set0(1, 0, 0, 0);
    @(negedge clk); chk("t4_rvalid", o_rvalid, 2'b01); chk("t4_rdata", o_rdata, 32'h5);
    tick(); set0(0, 0, 0, 0);
    @(negedge clk); chk("t4_rdata0", o_rdata, 0);

    // 6: req1 alone three times, then contention goes to req0
    tick();
    for (int j = 0; j < 3; j++) begin
      set1(1, 1, BW_ADDR'(10 + j), 32'hC0DE_0000 + 32'(j));
      @(negedge clk); chk("t6_solo_ready", o_ready, 2'b10);
      tick();
    end
    set0(1, 0, 10, 0); set1(1, 0, 11, 0);
    @(negedge clk); chk("t6_contend", o_ready, 2'b01);
    tick(); set0(0, 0, 0, 0);
    @(negedge clk); chk("t6_req1", o_ready, 2'b10); chk("t6_rdata0", o_rdata, 32'hC0DE_0000);
    tick(); set1(0, 0, 0, 0);
    @(negedge clk); chk("t6_rvalid1", o_rvalid, 2'b10); chk("t6_rdata1", o_rdata, 32'hC0DE_0001);

    // 5: reset right after a read accept drops the return and refills memory
    tick(); set0(1, 1, 20, 32'h1234_5678);
    @(negedge clk); chk("t5_wr_ready", o_ready, 2'b01);
    tick(); set0(1, 0, 20, 0);
    @(negedge clk); chk("t5_rd_ready", o_ready, 2'b01);
    tick(); rstn = 1'b0; set0(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_rvalid_drop", o_rvalid, 2'b00);
    chk("t5_done_clr", o_init_done, 1'b0);
    tick(); tick(); rstn = 1'b1;
    wait_init(n);
    chk("t5_init_cycles", n, 34);
    tick(); set0(1, 0, 20, 0);
    @(negedge clk); chk("t5_rd_ready2", o_ready, 2'b01);
    tick(); set0(1, 0, 3, 0);
    @(negedge clk); chk("t5_rvalid20", o_rvalid, 2'b01); chk("t5_rdata20", o_rdata, 0);
    tick(); set0(0, 0, 0, 0);
    @(negedge clk); chk("t5_rvalid3", o_rvalid, 2'b01); chk("t5_rdata3", o_rdata, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
